// File: rtl/step_motor_pkg.sv
// Shared types and helpers for the stepper sequencer.
//   state_e      : sequencer FSM states
//   idx_w()      : width of the phase index for a given coil count
//   coil_decode(): phase index -> one-hot / two-hot coil pattern (LSB = coil A)
package step_motor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest coil vector coil_decode() can produce; callers size-cast down to PHASES.
  localparam int MAX_PHASES = 8;

  function automatic int idx_w(input int phases);
    return $clog2(2 * phases);
  endfunction

  // Even index 2k energises coil k alone; odd index 2k+1 energises coils k and k+1,
  // with coil k+1 wrapping to coil 0 for the last odd index.
  function automatic logic [MAX_PHASES-1:0] coil_decode(input int unsigned idx,
                                                         input int unsigned phases);
    int unsigned          k;
    logic                 odd;
    logic [MAX_PHASES-1:0] res;
    k   = idx / 2;
    odd = ((idx % 2) == 1);
    res = '0;
    for (int unsigned j = 0; j < MAX_PHASES; j++) begin
      if (j == k || (odd && j == ((k + 1) % phases))) res[j] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate divider. Raises tick_o for one cycle every div_i+1 enabled cycles.
//   clk_i  : clock
//   cr_i   : synchronous active-high reset
//   clr_i  : hold the count at zero (sequencer idle or aborting)
//   en_i   : count enable; a frozen count resumes exactly where it stopped
//   div_i  : terminal count; period = div_i+1 enabled cycles
//   tick_o : combinational terminal-count strobe
module step_tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk_i,
  input  logic             cr_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // div_i is compared live, so a new period applies at the next compare.
  assign tick_o = en_i && !clr_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (cr_i) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/step_motor_ctrl.sv
// N-phase stepper sequencer with counted moves (start/busy/done handshake).
//   clk_i, cr_i   : clock, synchronous active-high reset
//   en_i          : 1 = run and energise coils, 0 = pause with coils off
//   start_i       : one-cycle move request, accepted only when idle
//   abort_i       : end the current move without a done pulse
//   dir_i         : 0 = forward (index up), 1 = reverse
//   half_i        : 1 = half-step, 0 = full-step
//   div_i         : step period = div_i+1 enabled cycles
//   steps_i       : number of steps in the move
//   busy_o        : move in progress
//   done_o        : one-cycle pulse with the final step (or for a zero-step move)
//   step_pulse_o  : one-cycle pulse per step
//   idx_o         : phase index 0..2*PHASES-1
//   coils_o       : coil drive, bit 0 = coil A
module step_motor_ctrl
  import step_motor_pkg::*;
#(
  parameter  int PHASES = 3,
  parameter  int DIV_W  = 32,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = idx_w(PHASES)
) (
  input  logic              clk_i,
  input  logic              cr_i,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              dir_i,
  input  logic              half_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [CNT_W-1:0]  steps_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              step_pulse_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [PHASES-1:0] coils_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * PHASES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_EVEN = IDX_W'(2 * PHASES - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_step;
  logic [PHASES-1:0] coils_q, coils_d;
  logic              done_q, done_d;
  logic              step_q, step_d;
  logic              tick;
  logic              tick_clr;

  assign tick_clr = (state_q != RUN) || abort_i;

  step_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk_i  (clk_i),
    .cr_i   (cr_i),
    .clr_i  (tick_clr),
    .en_i   (en_i),
    .div_i  (div_i),
    .tick_o (tick)
  );

  // Index after one step. A full step from an odd index lands on the adjacent
  // even index in the travel direction, which is the same move as a half step.
  always_comb begin
    idx_step = idx_q;
    if (half_i || idx_q[0]) begin
      if (!dir_i) idx_step = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      else        idx_step = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
    end else begin
      if (!dir_i) idx_step = (idx_q == IDX_LAST_EVEN) ? '0 : idx_q + IDX_W'(2);
      else        idx_step = (idx_q == '0) ? IDX_LAST_EVEN : idx_q - IDX_W'(2);
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (steps_i != '0) begin
            state_d = RUN;
            rem_d   = steps_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort wins over a tick in the same cycle: no step is taken.
        if (abort_i) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (tick) begin
          step_d = 1'b1;
          rem_d  = rem_q - CNT_W'(1);
          idx_d  = idx_step;
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    coils_d = en_i ? PHASES'(coil_decode(int'(idx_d), PHASES)) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (cr_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      coils_q <= '0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      coils_q <= coils_d;
      done_q  <= done_d;
      step_q  <= step_d;
    end
  end

  assign busy_o       = (state_q == RUN);
  assign done_o       = done_q;
  assign step_pulse_o = step_q;
  assign idx_o        = idx_q;
  assign coils_o      = coils_q;

endmodule

// File: tb/tb_step_motor_ctrl.sv
module tb_step_motor_ctrl;

  localparam int P  = 3;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int IW = $clog2(2 * P);

  logic          clk = 1'b0;
  logic          cr = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dir = 1'b0;
  logic          half = 1'b0;
  logic [DW-1:0] div = '0;
  logic [CW-1:0] steps = '0;
  logic          busy, done, step_pulse;
  logic [IW-1:0] idx;
  logic [P-1:0]  coils;

  step_motor_ctrl #(.PHASES(P), .DIV_W(DW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .cr_i         (cr),
    .en_i         (en),
    .start_i      (start),
    .abort_i      (abort),
    .dir_i        (dir),
    .half_i       (half),
    .div_i        (div),
    .steps_i      (steps),
    .busy_o       (busy),
    .done_o       (done),
    .step_pulse_o (step_pulse),
    .idx_o        (idx),
    .coils_o      (coils)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int coils;
    int gap;   // cycles since previous step (or start); 0 = not checked
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_step = 0;
  int   n_done = 0;
  int   cyc = 0;
  int   ref_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int c, input int gap, input bit last);
    exp_t e;
    e.idx = i; e.coils = c; e.gap = gap; e.last = last;
    sb.push_back(e);
  endtask

  // Step monitor: every step pulse pops the next expected step.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!cr) begin
      if (start && !busy) ref_cyc = cyc;
      if (done) n_done++;
      if (step_pulse) begin
        n_step++;
        if (sb.size() == 0) begin
          chk("unexpected_step", 32'(idx), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("step_idx", 32'(idx), 32'(e.idx));
          chk("step_coils", 32'(coils), 32'(e.coils));
          chk("done_with_step", 32'(done), 32'(e.last));
          if (e.gap != 0) chk("step_gap", 32'(cyc - ref_cyc), 32'(e.gap));
        end
        ref_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input bit d, input bit h, input int dv, input int st);
    dir = d; half = h; div = DW'(dv); steps = CW'(st);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 300), 32'd1);
    tick(2);
  endtask

  task automatic wait_steps(input int target, input string tag);
    int n;
    n = 0;
    while (n_step < target && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 300), 32'd1);
  endtask

  int s0, d0;

  initial begin
    // Reset state
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_step", 32'(step_pulse), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_coils", 32'(coils), 0);
    cr = 1'b0; en = 1'b1;
    tick(2);
    chk("idle_coils", 32'(coils), 32'b001);

    // T1: half forward through a full electrical cycle
    s0 = n_step; d0 = n_done;
    push(1, 3'b011, 5, 0); push(2, 3'b010, 4, 0); push(3, 3'b110, 4, 0);
    push(4, 3'b100, 4, 0); push(5, 3'b101, 4, 0); push(0, 3'b001, 4, 1);
    go(0, 1, 3, 6);
    chk("t1_busy", 32'(busy), 1);
    wait_idle("t1");
    chk("t1_idx", 32'(idx), 0);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_nstep", 32'(n_step - s0), 6);
    chk("t1_ndone", 32'(n_done - d0), 1);

    // T2: half reverse, wrap 0 -> 5, div=0
    push(5, 3'b101, 2, 0); push(4, 3'b100, 1, 1);
    go(1, 1, 0, 2);
    wait_idle("t2");
    chk("t2_idx", 32'(idx), 4);

    // T3: reach idx 1, then full forward from odd
    push(5, 3'b101, 3, 0); push(0, 3'b001, 2, 0); push(1, 3'b011, 2, 1);
    go(0, 1, 1, 3);
    wait_idle("t3a");
    push(2, 3'b010, 3, 0); push(4, 3'b100, 2, 0); push(0, 3'b001, 2, 1);
    go(0, 0, 1, 3);
    wait_idle("t3b");
    chk("t3_idx", 32'(idx), 0);
    // Full reverse from odd lands on the lower even index, then wraps evenly
    push(5, 3'b101, 3, 1);
    go(1, 1, 1, 1);
    wait_idle("t3c");
    push(4, 3'b100, 4, 0); push(2, 3'b010, 3, 1);
    go(1, 0, 2, 2);
    wait_idle("t3d");
    chk("t3d_idx", 32'(idx), 2);

    // T4: zero-step move
    d0 = n_done;
    go(0, 1, 3, 0);
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 0);
    tick();
    chk("t4_done_clr", 32'(done), 0);
    chk("t4_busy2", 32'(busy), 0);
    chk("t4_idx", 32'(idx), 2);
    chk("t4_ndone", 32'(n_done - d0), 1);

    // T5: pause after the second step
    s0 = n_step; d0 = n_done;
    push(4, 3'b100, 5, 0); push(0, 3'b001, 4, 0); push(2, 3'b010, 0, 0); push(4, 3'b100, 4, 1);
    go(0, 0, 3, 4);
    wait_steps(s0 + 2, "t5_two");
    en = 1'b0;
    tick();
    chk("t5_coils_off", 32'(coils), 0);
    tick(9);
    chk("t5_paused_steps", 32'(n_step - s0), 2);
    chk("t5_paused_busy", 32'(busy), 1);
    chk("t5_coils_off2", 32'(coils), 0);
    en = 1'b1;
    wait_idle("t5");
    chk("t5_nstep", 32'(n_step - s0), 4);
    chk("t5_ndone", 32'(n_done - d0), 1);

    // T6a: start during RUN is ignored
    s0 = n_step; d0 = n_done;
    push(5, 3'b101, 3, 0); push(0, 3'b001, 2, 0); push(1, 3'b011, 2, 1);
    go(0, 1, 1, 3);
    tick();
    steps = CW'(7); start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t6a");
    chk("t6a_nstep", 32'(n_step - s0), 3);
    chk("t6a_ndone", 32'(n_done - d0), 1);

    // T6b: abort mid-move
    s0 = n_step; d0 = n_done;
    push(2, 3'b010, 5, 0); push(3, 3'b110, 4, 0);
    go(0, 1, 3, 5);
    wait_steps(s0 + 2, "t6b_two");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6b_busy", 32'(busy), 0);
    chk("t6b_done", 32'(done), 0);
    tick(10);
    chk("t6b_idx", 32'(idx), 3);
    chk("t6b_nstep", 32'(n_step - s0), 2);
    chk("t6b_ndone", 32'(n_done - d0), 0);

    // T6c: start+abort together in IDLE (start wins), then reset mid-move
    s0 = n_step;
    push(4, 3'b100, 5, 0);
    abort = 1'b1;
    go(0, 1, 3, 5);
    abort = 1'b0;
    chk("t6c_busy", 32'(busy), 1);
    wait_steps(s0 + 1, "t6c_one");
    cr = 1'b1;
    tick();
    chk("t6c_rst_busy", 32'(busy), 0);
    chk("t6c_rst_done", 32'(done), 0);
    chk("t6c_rst_coils", 32'(coils), 0);
    chk("t6c_rst_idx", 32'(idx), 0);
    cr = 1'b0;
    tick(12);
    chk("t6c_nstep", 32'(n_step - s0), 1);
    chk("t6c_busy_after", 32'(busy), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
